// File: rtl/expr_eval_if.sv
// Character-stream bus between a stream source and the expression evaluator.
// The master drives characters; the slave returns the evaluation status.
interface expr_eval_if #(parameter int WIDTH = 8);
  logic             en;
  logic [7:0]       in;
  logic             out;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             ovf;

  modport master (output en, in, input out, result, err, ovf);
  modport slave  (input en, in, output out, result, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// Single-digit infix evaluator: '*' binds tighter than '+'. The value is kept
// as a committed sum plus the multiplicative term currently being built.
module expr_eval #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_NUM   = 3'd1,
    ST_ADD   = 3'd2,
    ST_MUL   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             out_s;
  logic             err_s;

  logic             is_digit_s;
  logic             is_plus_s;
  logic             is_star_s;
  logic [3:0]       d_s;
  logic [WIDTH:0]   add_full_s;
  logic [WIDTH+3:0] mul_full_s;

  // Character classification and full-precision arithmetic for overflow detection
  always_comb begin
    is_digit_s = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_plus_s  = (bus.in == 8'h2B);
    is_star_s  = (bus.in == 8'h2A);
    d_s        = bus.in[3:0];
    add_full_s = {1'b0, sum_q} + {1'b0, prod_q};
    mul_full_s = {4'b0000, prod_q} * {{WIDTH{1'b0}}, d_s};
  end

  // State and accumulator register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_START;
      sum_q    <= {WIDTH{1'b0}};
      prod_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and accumulator update; entering ERR freezes the accumulators
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    if (bus.en) begin
      case (state_q)
        ST_START: begin
          if (is_digit_s) begin
            state_d = ST_NUM;
            sum_d   = {WIDTH{1'b0}};
            prod_d  = {{(WIDTH-4){1'b0}}, d_s};
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_NUM: begin
          if (is_plus_s) begin
            state_d = ST_ADD;
            sum_d   = add_full_s[WIDTH-1:0];
            prod_d  = {WIDTH{1'b0}};
            ovf_d   = ovf_q | add_full_s[WIDTH];
          end else if (is_star_s) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_ADD: begin
          if (is_digit_s) begin
            state_d = ST_NUM;
            prod_d  = {{(WIDTH-4){1'b0}}, d_s};
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_MUL: begin
          if (is_digit_s) begin
            state_d = ST_NUM;
            prod_d  = mul_full_s[WIDTH-1:0];
            ovf_d   = ovf_q | (mul_full_s[WIDTH+3:WIDTH] != 4'h0);
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_ERR;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    result_d = sum_d + prod_d;
  end

  // Status outputs decoded from the registered state
  always_comb begin
    out_s = 1'b0;
    err_s = 1'b0;
    case (state_q)
      ST_NUM:  out_s = 1'b1;
      ST_ERR:  err_s = 1'b1;
      default: begin
        out_s = 1'b0;
        err_s = 1'b0;
      end
    endcase
  end

  assign bus.out    = out_s;
  assign bus.err    = err_s;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule
